// File: rtl/pid_gen_pkg.sv
// Shared encodings for the packet identifier gen-switch sequencer and mask decode.
package pid_gen_pkg;

  localparam logic [2:0] GEN1_SEL = 3'd0;
  localparam logic [2:0] GEN2_SEL = 3'd1;
  localparam logic [2:0] GEN3_SEL = 3'd2;
  localparam logic [2:0] GEN4_SEL = 3'd3;
  localparam logic [2:0] GEN5_SEL = 3'd4;

  localparam logic [3:0] ST_IDLE   = 4'b0001;
  localparam logic [3:0] ST_DRAIN  = 4'b0010;
  localparam logic [3:0] ST_APPLY  = 4'b0100;
  localparam logic [3:0] ST_SETTLE = 4'b1000;

  // Each PIPE data byte maps to 16 byte-valid lanes of the 64-bit mask.
  function automatic logic [63:0] pipe_mask(input int unsigned pw);
    int unsigned nb;
    nb = pw * 2;
    if (nb >= 64) return '1;
    return (64'd1 << nb) - 64'd1;
  endfunction

endpackage

// File: rtl/gen_mask_dec.sv
// Combinational gen code to 64-bit byte-valid mask; illegal codes give 0.
module gen_mask_dec
  import pid_gen_pkg::*;
#(
  parameter int unsigned GEN1_PIPEWIDTH = 8,
  parameter int unsigned GEN2_PIPEWIDTH = 16,
  parameter int unsigned GEN3_PIPEWIDTH = 32,
  parameter int unsigned GEN4_PIPEWIDTH = 8,
  parameter int unsigned GEN5_PIPEWIDTH = 8
) (
  input  logic [2:0]  gen,
  output logic [63:0] mask
);

  always_comb begin
    mask = '0;
    case (gen)
      GEN1_SEL: mask = pipe_mask(GEN1_PIPEWIDTH);
      GEN2_SEL: mask = pipe_mask(GEN2_PIPEWIDTH);
      GEN3_SEL: mask = pipe_mask(GEN3_PIPEWIDTH);
      GEN4_SEL: mask = pipe_mask(GEN4_PIPEWIDTH);
      GEN5_SEL: mask = pipe_mask(GEN5_PIPEWIDTH);
      default:  mask = '0;
    endcase
  end

endmodule

// File: rtl/gen_switch_ctrl.sv
// Timed gen switchover: hold datapath, wait for drain, apply new gen/mask, settle, release.
module gen_switch_ctrl
  import pid_gen_pkg::*;
#(
  parameter int unsigned GEN1_PIPEWIDTH = 8,
  parameter int unsigned GEN2_PIPEWIDTH = 16,
  parameter int unsigned GEN3_PIPEWIDTH = 32,
  parameter int unsigned GEN4_PIPEWIDTH = 8,
  parameter int unsigned GEN5_PIPEWIDTH = 8,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned DRAIN_TIMEOUT  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  gen_req,
  input  logic        gen_req_vld,
  output logic        gen_req_rdy,
  input  logic        pipe_busy,
  output logic        hold,
  output logic        w,
  output logic [2:0]  gen_cur,
  output logic [63:0] valid,
  output logic        gen_done,
  output logic        gen_err,
  output logic        timeout_err
);

  localparam int unsigned DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [63:0]   RST_MASK    = pipe_mask(GEN1_PIPEWIDTH);

  logic [3:0]    state;
  logic [2:0]    gen_nxt;
  logic [63:0]   mask_nxt;
  logic          idle_cnt;
  logic [DW-1:0] drain_cnt;
  logic [SW-1:0] settle_cnt;

  gen_mask_dec #(
    .GEN1_PIPEWIDTH(GEN1_PIPEWIDTH),
    .GEN2_PIPEWIDTH(GEN2_PIPEWIDTH),
    .GEN3_PIPEWIDTH(GEN3_PIPEWIDTH),
    .GEN4_PIPEWIDTH(GEN4_PIPEWIDTH),
    .GEN5_PIPEWIDTH(GEN5_PIPEWIDTH)
  ) u_mask_dec (
    .gen  (gen_nxt),
    .mask (mask_nxt)
  );

  assign gen_req_rdy = state[0];
  assign w           = state[0];
  assign hold        = |state[3:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      gen_nxt     <= GEN1_SEL;
      gen_cur     <= GEN1_SEL;
      valid       <= RST_MASK;
      idle_cnt    <= 1'b0;
      drain_cnt   <= '0;
      settle_cnt  <= '0;
      gen_done    <= 1'b0;
      gen_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      gen_done    <= 1'b0;
      gen_err     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gen_req_vld) begin
            if (gen_req > GEN5_SEL) begin
              gen_err <= 1'b1;
            end else if (gen_req == gen_cur) begin
              gen_done <= 1'b1;
            end else begin
              gen_nxt   <= gen_req;
              idle_cnt  <= 1'b0;
              drain_cnt <= '0;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // idle_cnt only needs to remember "previous cycle was idle".
          idle_cnt  <= ~pipe_busy;
          drain_cnt <= drain_cnt + 1'b1;
          if (!pipe_busy && idle_cnt) begin
            state <= ST_APPLY;
          end else if (drain_cnt == DRAIN_LAST) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_APPLY: begin
          gen_cur    <= gen_nxt;
          valid      <= mask_nxt;
          settle_cnt <= '0;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == SETTLE_LAST) begin
            gen_done <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
